// File: rtl/order_tx_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | order_tx_serializer_pkg : shared constants and state encoding         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package order_tx_serializer_pkg;

  localparam logic [7:0]  HDR_BYTE = 8'hA5;
  localparam int unsigned MSG_LEN  = 13;
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/order_tx_serializer_frame_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | order_frame_mux : selects the outbound frame byte by index            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module order_frame_mux
  import order_tx_serializer_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             side_i,
  input  logic [15:0]      id_i,
  input  logic [31:0]      price_i,
  input  logic [31:0]      size_i,
  input  logic [7:0]       csum_i,
  output logic [7:0]       byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      4'd0:    byte_o = HDR_BYTE;
      4'd1:    byte_o = {7'b0, side_i};
      4'd2:    byte_o = id_i[15:8];
      4'd3:    byte_o = id_i[7:0];
      4'd4:    byte_o = price_i[31:24];
      4'd5:    byte_o = price_i[23:16];
      4'd6:    byte_o = price_i[15:8];
      4'd7:    byte_o = price_i[7:0];
      4'd8:    byte_o = size_i[31:24];
      4'd9:    byte_o = size_i[23:16];
      4'd10:   byte_o = size_i[15:8];
      4'd11:   byte_o = size_i[7:0];
      4'd12:   byte_o = csum_i;
      default: byte_o = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/order_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | order_tx_serializer : frames one order, waits for ack, enforces gap   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module order_tx_serializer
  import order_tx_serializer_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned MIN_GAP     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        order_req,
  input  logic [31:0] order_price,
  input  logic [31:0] order_size,
  input  logic        order_side,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        ack_valid,
  input  logic [15:0] ack_id,
  output logic        busy,
  output logic        order_acked,
  output logic        order_timeout,
  output logic [15:0] drop_count,
  output logic [15:0] last_id
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);
  localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      price_q, price_d, size_q, size_d;
  logic             side_q, side_d;
  logic [15:0]      id_q, id_d, next_id_q, next_id_d, drop_q, drop_d;
  logic [7:0]       csum_q, csum_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             acked_q, acked_d, tmo_q, tmo_d;
  logic [7:0]       w_byte;

  order_frame_mux u_mux (
    .idx_i   (idx_q),
    .side_i  (side_q),
    .id_i    (id_q),
    .price_i (price_q),
    .size_i  (size_q),
    .csum_i  (csum_q),
    .byte_o  (w_byte)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    price_d   = price_q;
    size_d    = size_q;
    side_d    = side_q;
    id_d      = id_q;
    next_id_d = next_id_q;
    drop_d    = drop_q;
    csum_d    = csum_q;
    tmr_d     = tmr_q;
    gap_d     = gap_q;
    acked_d   = 1'b0;
    tmo_d     = 1'b0;

    if (order_req && (state_q != ST_IDLE) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (order_req) begin
          price_d   = order_price;
          size_d    = order_size;
          side_d    = order_side;
          id_d      = next_id_q;
          next_id_d = next_id_q + 16'd1;
          idx_d     = '0;
          csum_d    = 8'h00;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          // Running XOR: by the time idx reaches the last slot it holds bytes 0..11.
          csum_d = csum_q ^ w_byte;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            tmr_d   = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT_ACK: begin
        tmr_d = tmr_q + TW'(1);
        if ((ack_valid && (ack_id == id_q)) || (tmr_q == TMR_LAST)) begin
          // A matching ack takes priority over an expiring timer.
          acked_d = ack_valid && (ack_id == id_q);
          tmo_d   = !acked_d;
          gap_d   = '0;
          state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      price_q   <= '0;
      size_q    <= '0;
      side_q    <= 1'b0;
      id_q      <= '0;
      next_id_q <= '0;
      drop_q    <= '0;
      csum_q    <= '0;
      tmr_q     <= '0;
      gap_q     <= '0;
      acked_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      price_q   <= price_d;
      size_q    <= size_d;
      side_q    <= side_d;
      id_q      <= id_d;
      next_id_q <= next_id_d;
      drop_q    <= drop_d;
      csum_q    <= csum_d;
      tmr_q     <= tmr_d;
      gap_q     <= gap_d;
      acked_q   <= acked_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tx_valid      = (state_q == ST_SEND);
  assign tx_data       = tx_valid ? w_byte : 8'h00;
  assign busy          = (state_q != ST_IDLE);
  assign order_acked   = acked_q;
  assign order_timeout = tmo_q;
  assign drop_count    = drop_q;
  assign last_id       = id_q;

endmodule
`default_nettype wire

// File: tb/tb_order_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_order_tx_serializer : randomized bench against a frame-level model |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_order_tx_serializer;

  localparam int ACK_TO = 1000;
  localparam int GAP    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        order_req = 1'b0;
  logic [31:0] order_price = '0;
  logic [31:0] order_size = '0;
  logic        order_side = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        ack_valid = 1'b0;
  logic [15:0] ack_id = '0;
  logic        busy, order_acked, order_timeout;
  logic [15:0] drop_count, last_id;

  order_tx_serializer #(.ACK_TIMEOUT(ACK_TO), .MIN_GAP(GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .order_req     (order_req),
    .order_price   (order_price),
    .order_size    (order_size),
    .order_side    (order_side),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .ack_valid     (ack_valid),
    .ack_id        (ack_id),
    .busy          (busy),
    .order_acked   (order_acked),
    .order_timeout (order_timeout),
    .drop_count    (drop_count),
    .last_id       (last_id)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_next_id = '0;
  int          m_drops   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Frame per the message rules: header, side, id, price, size, XOR checksum.
  function automatic logic [7:0] frame_byte(input int i, input logic [31:0] p, input logic [31:0] s,
                                            input logic sd, input logic [15:0] id);
    logic [95:0] body;
    logic [7:0]  x;
    body = {8'hA5, 7'b0, sd, id, p, s};
    x = 8'h00;
    if (i < 12) return body[95-8*i -: 8];
    for (int k = 0; k < 12; k++) x ^= body[95-8*k -: 8];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [31:0] s, input logic sd,
                            input int rmode, input int ndrop);
    logic [7:0]  got[$];
    logic [7:0]  prev;
    logic        stalled;
    logic [15:0] id;
    int          cyc, drops_left;
    id = m_next_id;
    order_req = 1'b1; order_price = p; order_size = s; order_side = sd;
    step();
    order_req = 1'b0;
    m_next_id = m_next_id + 16'd1;
    check("latency_valid", 32'(tx_valid), 32'd1);
    check("busy_send", 32'(busy), 32'd1);
    check("last_id", 32'(last_id), 32'(id));
    stalled = 1'b0; prev = 8'h00; cyc = 0; drops_left = ndrop;
    while (got.size() < 13 && cyc < 200) begin
      if (stalled) check("stall_hold", 32'(tx_data), 32'(prev));
      check("no_ack_in_send", 32'(order_acked), 32'd0);
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      order_req = 1'b0; ack_valid = 1'b0;
      if (drops_left > 0 && cyc > 0) begin
        order_req = 1'b1; order_price = $urandom; order_size = $urandom;
        order_side = 1'($urandom_range(0, 1));
        drops_left--; m_drops++;
      end
      if ($urandom_range(0, 3) == 0) begin ack_valid = 1'b1; ack_id = id; end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      stalled = tx_valid && !tx_ready;
      prev = tx_data;
      step();
      cyc++;
    end
    order_req = 1'b0; ack_valid = 1'b0; tx_ready = 1'b1;
    check("frame_len", 32'(got.size()), 32'd13);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("frame_byte%0d", k), 32'(got[k]), 32'(frame_byte(k, p, s, sd, id)));
    check("tx_valid_after", 32'(tx_valid), 32'd0);
    check("drop_count_send", 32'(drop_count), 32'(m_drops));
  endtask

  // t counts edges after the final byte transfer; an ack driven at t lands on edge t+1.
  task automatic wait_ack(input bit use_ack, input int c_ack, input int c_wrong);
    logic [15:0] id;
    int exp_pulse, exp_idle, t, seen, idle_at, n_ack, n_tmo;
    bit exp_acked;
    id = m_next_id - 16'd1;
    exp_acked = use_ack && (c_ack < ACK_TO);
    exp_pulse = exp_acked ? c_ack + 1 : ACK_TO;
    exp_idle  = exp_pulse + GAP;
    t = 0; seen = -1; idle_at = -1; n_ack = 0; n_tmo = 0;
    while (idle_at < 0 && t < ACK_TO + GAP + 20) begin
      order_req = 1'b0; ack_valid = 1'b0;
      if (use_ack && t == c_ack) begin ack_valid = 1'b1; ack_id = id; end
      else if (t == c_wrong) begin ack_valid = 1'b1; ack_id = id ^ 16'h0001; end
      else if (t == exp_pulse + 1) begin ack_valid = 1'b1; ack_id = id; end
      if (t == 1 || t == exp_idle - 1) begin order_req = 1'b1; order_price = $urandom; m_drops++; end
      step();
      t++;
      if (order_acked) n_ack++;
      if (order_timeout) n_tmo++;
      if ((order_acked || order_timeout) && seen < 0) seen = t;
      if (!busy) idle_at = t;
    end
    order_req = 1'b0; ack_valid = 1'b0;
    check("pulse_cycle", 32'(seen), 32'(exp_pulse));
    check("acked_pulses", 32'(n_ack), exp_acked ? 32'd1 : 32'd0);
    check("timeout_pulses", 32'(n_tmo), exp_acked ? 32'd0 : 32'd1);
    check("busy_fall", 32'(idle_at), 32'(exp_idle));
    step();
    check("boundary_req_dropped", 32'(busy), 32'd0);
    check("drop_count_gap", 32'(drop_count), 32'(m_drops));
    check("last_id_kept", 32'(last_id), 32'(id));
  endtask

  initial begin
    logic [31:0] p, s;
    logic        sd;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acked", 32'(order_acked), 32'd0);
    check("rst_timeout", 32'(order_timeout), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_last_id", 32'(last_id), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed frame, wrong-id ack first then the matching one.
    send_frame(32'h0000_1234, 32'h0000_0064, 1'b1, 0, 0);
    wait_ack(1'b1, 20, 8);
    // Stalling sink; ack coincident with the timeout.
    send_frame($urandom, $urandom, 1'b0, 1, 0);
    wait_ack(1'b1, ACK_TO - 1, 5);
    // No ack at all.
    send_frame($urandom, $urandom, 1'b1, 2, 1);
    wait_ack(1'b0, 0, -1);

    for (int n = 0; n < 8; n++) begin
      send_frame($urandom, $urandom, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      wait_ack(1'b1, int'($urandom_range(0, 40)), int'($urandom_range(41, 60)));
    end

    // Reset mid-frame while byte 6 is on the wire.
    p = $urandom; s = $urandom; sd = 1'($urandom_range(0, 1));
    order_req = 1'b1; order_price = p; order_size = s; order_side = sd;
    tx_ready = 1'b1;
    step();
    order_req = 1'b0;
    repeat (6) step();
    check("mid_byte6", 32'(tx_data), 32'(frame_byte(6, p, s, sd, m_next_id)));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_data", 32'(tx_data), 32'd0);
    check("async_rst_last_id", 32'(last_id), 32'd0);
    check("async_rst_drops", 32'(drop_count), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    m_next_id = '0;
    m_drops   = 0;
    step();

    // Three requests during SEND after reset: frame starts fresh with id 0.
    send_frame($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 3);
    check("drop_count_three", 32'(drop_count), 32'd3);
    wait_ack(1'b1, 3, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
